// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs1_d, rs2_d;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    logic [REG_AW-1:0] rd_m, rd_w;
    logic              mem_read_e;
    logic              reg_write_m, reg_write_w;
    logic              pc_src_e;
    logic              md_start_e;
    logic              dmem_req_m, dmem_ready;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_m, flush_w;
    logic [1:0]        fwd_a_e, fwd_b_e;
    logic              mem_err;

    // Pipeline side: supplies stage information, consumes controls.
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
               mem_read_e, reg_write_m, reg_write_w, pc_src_e,
               md_start_e, dmem_req_m, dmem_ready,
        input  stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w,
               fwd_a_e, fwd_b_e, mem_err
    );

    // Controller side.
    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
               mem_read_e, reg_write_m, reg_write_w, pc_src_e,
               md_start_e, dmem_req_m, dmem_ready,
        output stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w,
               fwd_a_e, fwd_b_e, mem_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage forwarding select for a single source operand; M beats W.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd
);

    // Youngest producer wins; register 0 is never forwarded.
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs_e))
            fwd = FWD_M;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e))
            fwd = FWD_W;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use bubbles, branch flushes,
// MUL/DIV freezes, dmem wait states with timeout abort, EX forwarding.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MD_LAT      = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    hz_state_t        state, state_n;
    logic [CNT_W-1:0] md_cnt, md_cnt_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;

    logic abort, freeze, load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic st_f, st_d, st_e, st_m;
    logic fl_d, fl_e, fl_m, fl_w;
    logic err;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e        (hz.rs1_e),
        .rd_m        (hz.rd_m),
        .rd_w        (hz.rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .fwd         (fwd_a_raw)
    );

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e        (hz.rs2_e),
        .rd_m        (hz.rd_m),
        .rd_w        (hz.rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .fwd         (fwd_b_raw)
    );

    // Abort cycle ignores the dmem request, so it can never freeze.
    assign abort    = (state == MEM_WAIT) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    assign freeze   = hz.dmem_req_m && !hz.dmem_ready && !abort;
    assign load_use = hz.mem_read_e && (hz.rd_e != '0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            md_cnt   <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            md_cnt   <= md_cnt_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // Next-state and stall/flush decode; priority freeze > md > branch > load-use.
    always_comb begin
        state_n    = state;
        md_cnt_n   = md_cnt;
        wait_cnt_n = wait_cnt;
        st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
        fl_d = 1'b0; fl_e = 1'b0; fl_m = 1'b0; fl_w = 1'b0;
        err  = 1'b0;

        unique case (state)
            MD_BUSY: begin
                if (freeze) begin
                    // md_cnt is held so the op still sees its full latency.
                    st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1;
                    fl_w = 1'b1;
                end else if (md_cnt != '0) begin
                    st_f = 1'b1; st_d = 1'b1; st_e = 1'b1;
                    fl_m = 1'b1;
                    md_cnt_n = md_cnt - 1'b1;
                end else begin
                    state_n = RUN;
                end
            end
            default: begin
                if (freeze) begin
                    st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1;
                    fl_w = 1'b1;
                    state_n    = MEM_WAIT;
                    wait_cnt_n = (state == RUN) ? CNT_W'(1) : wait_cnt + 1'b1;
                end else begin
                    err        = abort;
                    state_n    = RUN;
                    wait_cnt_n = '0;
                    if (hz.md_start_e) begin
                        st_f = 1'b1; st_d = 1'b1; st_e = 1'b1;
                        fl_m = 1'b1;
                        state_n  = MD_BUSY;
                        md_cnt_n = CNT_W'(MD_LAT - 1);
                    end else if (hz.pc_src_e) begin
                        fl_d = 1'b1;
                        fl_e = 1'b1;
                    end else if (load_use) begin
                        st_f = 1'b1; st_d = 1'b1;
                        fl_e = 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs are forced quiet while reset is held low.
    always_comb begin
        hz.stall_f = reset & st_f;
        hz.stall_d = reset & st_d;
        hz.stall_e = reset & st_e;
        hz.stall_m = reset & st_m;
        hz.flush_d = reset & fl_d;
        hz.flush_e = reset & fl_e;
        hz.flush_m = reset & fl_m;
        hz.flush_w = reset & fl_w;
        hz.mem_err = reset & err;
        hz.fwd_a_e = reset ? fwd_a_raw : FWD_RF;
        hz.fwd_b_e = reset ? fwd_b_raw : FWD_RF;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a scoreboard of expected outputs.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

    pipe_hazard_ctrl #(
        .REG_AW      (5),
        .MD_LAT      (4),
        .MEM_TIMEOUT (16),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,mem_err,fwd_a[1:0],fwd_b[1:0]}
    localparam logic [12:0] O_NONE = 13'b0;
    localparam logic [12:0] O_LU   = 13'b1100_0100_0_00_00;
    localparam logic [12:0] O_BR   = 13'b0000_1100_0_00_00;
    localparam logic [12:0] O_MD   = 13'b1110_0010_0_00_00;
    localparam logic [12:0] O_FRZ  = 13'b1111_0001_0_00_00;
    localparam logic [12:0] O_ERR  = 13'b0000_0000_1_00_00;

    logic [12:0] sb_q[$];
    string       tag_q[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [12:0] observed();
        return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
                hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w,
                hz.mem_err, hz.fwd_a_e, hz.fwd_b_e};
    endfunction

    // One clock cycle: inputs already driven; expectation queued, checked mid-cycle.
    task automatic step(input string tag, input logic [12:0] exp);
        logic [12:0] e;
        logic [12:0] o;
        string       t;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0;
        hz.rd_e = '0; hz.rd_m = '0; hz.rd_w = '0;
        hz.mem_read_e = 1'b0; hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0;
        hz.pc_src_e = 1'b0; hz.md_start_e = 1'b0;
        hz.dmem_req_m = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    initial begin
        // Reset held with every hazard source active: outputs must stay quiet.
        reset = 1'b0;
        clear_inputs();
        hz.mem_read_e = 1'b1; hz.rd_e = 5'd5; hz.rs1_d = 5'd5;
        hz.pc_src_e = 1'b1; hz.md_start_e = 1'b1; hz.dmem_req_m = 1'b1;
        hz.rd_m = 5'd3; hz.reg_write_m = 1'b1; hz.rs1_e = 5'd3; hz.rs2_e = 5'd3;
        @(posedge clk); #1;
        step("reset0", O_NONE);
        step("reset1", O_NONE);
        reset = 1'b1;
        clear_inputs();
        step("idle", O_NONE);

        // Load-use via rs1 and via rs2, then the bubble releases.
        hz.mem_read_e = 1'b1; hz.rd_e = 5'd5; hz.rs1_d = 5'd5;
        step("lu_rs1", O_LU);
        hz.mem_read_e = 1'b0;
        step("lu_after", O_NONE);
        hz.mem_read_e = 1'b1; hz.rd_e = 5'd9; hz.rs1_d = 5'd1; hz.rs2_d = 5'd9;
        step("lu_rs2", O_LU);
        hz.rd_e = 5'd0; hz.rs1_d = 5'd0; hz.rs2_d = 5'd0;
        step("lu_x0", O_NONE);
        clear_inputs();

        // Branch beats load-use.
        hz.mem_read_e = 1'b1; hz.rd_e = 5'd5; hz.rs1_d = 5'd5; hz.pc_src_e = 1'b1;
        step("br_over_lu", O_BR);
        clear_inputs();
        step("br_after", O_NONE);

        // MUL/DIV: four stall cycles, fifth releases even with md_start_e still high.
        hz.md_start_e = 1'b1; hz.pc_src_e = 1'b1;
        for (int unsigned i = 0; i < 4; i++) step("md_stall", O_MD);
        step("md_release", O_NONE);
        clear_inputs();
        step("md_idle", O_NONE);

        // Short dmem wait.
        hz.dmem_req_m = 1'b1; hz.dmem_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) step("mem_wait", O_FRZ);
        hz.dmem_ready = 1'b1;
        step("mem_ready", O_NONE);
        clear_inputs();
        step("mem_idle", O_NONE);

        // Timeout: 16 freezes, abort pulse, then the stuck request freezes afresh.
        hz.dmem_req_m = 1'b1; hz.dmem_ready = 1'b0;
        for (int unsigned i = 0; i < 16; i++) step("to_freeze", O_FRZ);
        step("to_abort", O_ERR);
        step("to_refreeze", O_FRZ);
        hz.dmem_req_m = 1'b0;
        step("to_idle", O_NONE);

        // Freeze outranks a new MUL/DIV.
        hz.dmem_req_m = 1'b1; hz.md_start_e = 1'b1;
        step("frz_over_md", O_FRZ);
        clear_inputs();
        step("frz_md_idle", O_NONE);

        // Freeze inside MD_BUSY holds the md count.
        hz.md_start_e = 1'b1;
        step("mdf_start", O_MD);
        hz.dmem_req_m = 1'b1;
        step("mdf_freeze", O_FRZ);
        hz.dmem_req_m = 1'b0;
        for (int unsigned i = 0; i < 3; i++) step("mdf_stall", O_MD);
        step("mdf_release", O_NONE);
        clear_inputs();
        step("mdf_idle", O_NONE);

        // Forwarding.
        hz.rd_m = 5'd7; hz.rd_w = 5'd7; hz.reg_write_m = 1'b1; hz.reg_write_w = 1'b1;
        hz.rs1_e = 5'd7; hz.rs2_e = 5'd2;
        step("fwd_a_m", 13'b0000_0000_0_10_00);
        hz.rd_m = 5'd0;
        step("fwd_a_w", 13'b0000_0000_0_01_00);
        hz.rs2_e = 5'd7; hz.rd_m = 5'd7; hz.reg_write_m = 1'b0;
        step("fwd_ab_w", 13'b0000_0000_0_01_01);
        hz.reg_write_w = 1'b0;
        step("fwd_none", 13'b0000_0000_0_00_00);
        hz.rd_m = 5'd4; hz.reg_write_m = 1'b1; hz.rs2_e = 5'd4;
        hz.rd_w = 5'd0; hz.reg_write_w = 1'b1; hz.rs1_e = 5'd0;
        step("fwd_b_m_x0", 13'b0000_0000_0_00_10);
        clear_inputs();

        // Reset mid MUL/DIV discards the count.
        hz.md_start_e = 1'b1;
        step("rmd_start", O_MD);
        reset = 1'b0;
        step("rmd_reset", O_NONE);
        reset = 1'b1;
        hz.md_start_e = 1'b0;
        step("rmd_after", O_NONE);
        step("rmd_after2", O_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
